// File: rtl/sobel_gradient.sv
// Three-stage Sobel gradient-magnitude pipeline with a global advance.
// S1 holds the column and row sums. S2 holds signed Gx and Gy. S3 holds the
// saturated magnitude and the edge flag.
// A consumed-result counter can be cleared synchronously.
// The edge flag is named is_edge because "edge" is a reserved word in SystemVerilog.
module sobel_gradient #(
  parameter logic [7:0] THRESH = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        win_valid,
  input  logic [7:0]  win_data [9],
  output logic        win_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  mag,
  output logic        is_edge,
  output logic [15:0] pix_count,
  input  logic        count_clr
);

  logic        adv;
  logic        s1_valid, s2_valid;
  logic [9:0]  s1_gxp, s1_gxn, s1_gyp, s1_gyn;
  logic signed [10:0] s2_gx, s2_gy;

  logic [9:0]  gxp_d, gxn_d, gyp_d, gyn_d;
  logic [10:0] abs_gx, abs_gy;
  logic [11:0] sum_d;
  logic [7:0]  mag_d;
  logic        edge_d;

  // A stalled output freezes every stage, so the whole pipe shares one enable.
  assign adv       = !out_valid || out_ready;
  assign win_ready = adv;

  // Weighted column and row sums. Each sum is at most 4*255 = 1020.
  always_comb begin
    gxp_d = {2'b00, win_data[2]} + {1'b0, win_data[5], 1'b0} + {2'b00, win_data[8]};
    gxn_d = {2'b00, win_data[0]} + {1'b0, win_data[3], 1'b0} + {2'b00, win_data[6]};
    gyp_d = {2'b00, win_data[6]} + {1'b0, win_data[7], 1'b0} + {2'b00, win_data[8]};
    gyn_d = {2'b00, win_data[0]} + {1'b0, win_data[1], 1'b0} + {2'b00, win_data[2]};
  end

  // Absolute values, a 12-bit sum that cannot wrap, then saturation to 8 bits.
  always_comb begin
    abs_gx = s2_gx[10] ? 11'(-s2_gx) : 11'(s2_gx);
    abs_gy = s2_gy[10] ? 11'(-s2_gy) : 11'(s2_gy);
    sum_d  = {1'b0, abs_gx} + {1'b0, abs_gy};
    mag_d  = (sum_d > 12'd255) ? 8'hFF : sum_d[7:0];
    edge_d = (mag_d >= THRESH);
  end

  // Pipeline registers: all stages move together on adv and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_gxp    <= '0;
      s1_gxn    <= '0;
      s1_gyp    <= '0;
      s1_gyn    <= '0;
      s2_gx     <= '0;
      s2_gy     <= '0;
      mag       <= '0;
      is_edge   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= win_valid;
      s1_gxp    <= gxp_d;
      s1_gxn    <= gxn_d;
      s1_gyp    <= gyp_d;
      s1_gyn    <= gyn_d;
      s2_valid  <= s1_valid;
      s2_gx     <= $signed({1'b0, s1_gxp}) - $signed({1'b0, s1_gxn});
      s2_gy     <= $signed({1'b0, s1_gyp}) - $signed({1'b0, s1_gyn});
      out_valid <= s2_valid;
      mag       <= mag_d;
      is_edge   <= edge_d;
    end
  end

  // Count consumed results. A clear wins over a coincident consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count <= '0;
    end else if (count_clr) begin
      pix_count <= '0;
    end else if (out_valid && out_ready) begin
      pix_count <= pix_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Scoreboard bench for sobel_gradient.
// The stimulus process pushes hand-computed results as windows are offered.
// The monitor process pops and compares every consumed result.
module tb_sobel_gradient;

  localparam logic [7:0] THRESH = 8'd64;

  logic        clk = 1'b0;
  logic        rst;
  logic        win_valid;
  logic [7:0]  win_data [9];
  logic        win_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  mag;
  logic        is_edge;
  logic [15:0] pix_count;
  logic        count_clr;

  int checks = 0;
  int passes = 0;

  logic [8:0]  exp_q [$];
  logic [7:0]  v [9];

  sobel_gradient #(.THRESH(THRESH)) dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .is_edge(is_edge),
    .pix_count(pix_count), .count_clr(count_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Offer the window in v until it is accepted, then queue its expected result.
  task automatic send(input logic [7:0] em);
    int n = 0;
    for (int i = 0; i < 9; i++) win_data[i] = v[i];
    win_valid = 1'b1;
    @(negedge clk);
    while (!win_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    exp_q.push_back({em, (em >= THRESH)});
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic one_px(input int idx, input logic [7:0] val);
    for (int i = 0; i < 9; i++) v[i] = 8'd0;
    v[idx] = val;
  endtask

  // Monitor: score consumed results and check stability while stalled.
  logic       was_stalled = 1'b0;
  logic [7:0] held_mag;
  logic       held_edge;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (was_stalled) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_mag", int'(mag), int'(held_mag));
        chk("stall_edge", int'(is_edge), int'(held_edge));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got mag %0d expected no result at %0t", mag, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mag", int'(mag), int'(e[8:1]));
          chk("edge", int'(is_edge), int'(e[0]));
        end
      end
      if (out_valid && !out_ready) chk("win_ready_stall", int'(win_ready), 0);
      was_stalled = out_valid && !out_ready;
      held_mag    = mag;
      held_edge   = is_edge;
    end else begin
      was_stalled = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; win_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin win_data[i] = 8'd0; v[i] = 8'd0; end
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mag", int'(mag), 0);
    chk("rst_edge", int'(is_edge), 0);
    chk("rst_pix_count", int'(pix_count), 0);
    chk("rst_win_ready", int'(win_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All-zero window: latency 3 and a count of 1 after the consume.
    send(8'd0);
    @(posedge clk); #1 chk("lat_n2", int'(out_valid), 0);
    @(posedge clk); #1 chk("lat_n3", int'(out_valid), 1);
    @(posedge clk); #1 chk("count_after_first", int'(pix_count), 1);
    drain();

    // Saturating, small, boundary and negative windows, back to back.
    v = '{8'd0, 8'd100, 8'd255, 8'd0, 8'd100, 8'd255, 8'd0, 8'd100, 8'd255};
    send(8'd255);
    one_px(2, 8'd10);   send(8'd20);
    one_px(5, 8'd31);   send(8'd62);
    one_px(5, 8'd32);   send(8'd64);
    one_px(8, 8'd127);  send(8'd254);
    one_px(8, 8'd128);  send(8'd255);
    v = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    send(8'd255);
    drain();

    // Five-window stream with out_ready low for cycles 4-7.
    fork
      begin
        one_px(0, 8'd50);  send(8'd100);
        one_px(4, 8'd200); send(8'd0);
        one_px(7, 8'd20);  send(8'd40);
        one_px(3, 8'd30);  send(8'd60);
        one_px(5, 8'd32);  send(8'd64);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three windows in flight.
    one_px(1, 8'd90); send(8'd180);
    one_px(6, 8'd40); send(8'd80);
    one_px(2, 8'd5);  send(8'd10);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pix_count", int'(pix_count), 0);
    chk("midrst_win_ready", int'(win_ready), 1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 chk("no_stale", int'(out_valid), 0);
    end

    // First window after reset still takes three cycles.
    one_px(8, 8'd20); send(8'd40);
    @(posedge clk); #1 chk("post_rst_lat_n2", int'(out_valid), 0);
    @(posedge clk); #1 chk("post_rst_lat_n3", int'(out_valid), 1);
    drain();
    chk("post_rst_count", int'(pix_count), 1);

    // Clear with no consume pending.
    count_clr = 1'b1;
    @(posedge clk); #1 count_clr = 1'b0;
    chk("clr_idle", int'(pix_count), 0);

    // Preload the counter to 16'hFFFF, then wrap it.
    for (int i = 0; i < 9; i++) v[i] = 8'd0;
    for (int i = 0; i < 65535; i++) send(8'd0);
    drain();
    chk("count_ffff", int'(pix_count), 65535);
    send(8'd0);
    drain();
    chk("count_wrap", int'(pix_count), 0);

    // Clear coincident with a consume.
    send(8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_consume_valid", int'(out_valid), 1);
    count_clr = 1'b1;
    @(posedge clk); #1 count_clr = 1'b0;
    chk("clr_consume_count", int'(pix_count), 0);
    drain();
    base = int'(pix_count);
    chk("final_count", base, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
